// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared encodings, FSM states and request record for the load/store controller.
package lsu_mem_ctrl_pkg;

    localparam logic [1:0] SizeByte = 2'b00;
    localparam logic [1:0] SizeHalf = 2'b01;
    localparam logic [1:0] SizeWord = 2'b10;
    localparam logic [1:0] SizeIll  = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StRd,
        StWr,
        StResp
    } state_e;

    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [1:0]  lane;
        logic [31:0] wdata;
    } lsu_req_t;

    // An access faults when it cannot fit inside the 4-byte window at the clamped base.
    function automatic logic access_fault(input logic [1:0] size, input logic [1:0] lane);
        logic f;
        case (size)
            SizeByte: f = 1'b0;
            SizeHalf: f = (lane == 2'd3);
            SizeWord: f = (lane != 2'd0);
            default:  f = 1'b1;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/lsu_mem_ctrl_lane_align.sv
// Lane extraction with sign/zero extension for loads, and lane merge for sub-word stores.
module lsu_mem_ctrl_lane_align
    import lsu_mem_ctrl_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [4:0]  shamt;
    logic [31:0] shifted;
    logic [31:0] mask;

    always_comb begin
        shamt   = {lane, 3'b000};
        shifted = rdata >> shamt;

        case (size)
            SizeByte: load_data = {{24{~uns & shifted[7]}}, shifted[7:0]};
            SizeHalf: load_data = {{16{~uns & shifted[15]}}, shifted[15:0]};
            default:  load_data = rdata;
        endcase

        mask   = ((size == SizeByte) ? 32'h0000_00FF : 32'h0000_FFFF) << shamt;
        merged = (rdata & ~mask) | ((wdata << shamt) & mask);
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Single-outstanding load/store controller for a byte-addressed 32-bit RAM with RMW sub-word stores.
module lsu_mem_ctrl
    import lsu_mem_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_fault,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int unsigned       RamBytes = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] WinMax   = ADDR_W'(RamBytes - 4);

    state_e            state_q, state_d;
    lsu_req_t          req_q, req_d;
    logic [31:0]       rd_q, rd_d;
    logic              resp_valid_q, resp_valid_d;
    logic [31:0]       resp_rdata_q, resp_rdata_d;
    logic              resp_fault_q, resp_fault_d;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [31:0]       ram_wdata_q, ram_wdata_d;

    logic [ADDR_W-1:0] base;
    logic [1:0]        lane_in;
    logic [31:0]       rd_word;
    logic [31:0]       load_data;
    logic [31:0]       merged;

    // In RD the async word is consumed the same edge it is captured into rd_q.
    assign rd_word = (state_q == StRd) ? ram_rdata : rd_q;

    lsu_mem_ctrl_lane_align u_lane_align (
        .rdata     (rd_word),
        .lane      (req_q.lane),
        .size      (req_q.size),
        .uns       (req_q.uns),
        .wdata     (req_q.wdata),
        .load_data (load_data),
        .merged    (merged)
    );

    always_comb begin
        base    = (req_addr > WinMax) ? WinMax : req_addr;
        lane_in = 2'(req_addr - base);

        state_d      = state_q;
        req_d        = req_q;
        rd_d         = rd_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = '0;
        resp_fault_d = 1'b0;
        ram_we_d     = 1'b0;
        ram_addr_d   = ram_addr_q;
        ram_wdata_d  = ram_wdata_q;

        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    req_d.we    = req_we;
                    req_d.size  = req_size;
                    req_d.uns   = req_unsigned;
                    req_d.lane  = lane_in;
                    req_d.wdata = req_wdata;
                    ram_addr_d  = base;
                    if (access_fault(req_size, lane_in)) begin
                        state_d      = StResp;
                        resp_valid_d = 1'b1;
                        resp_fault_d = 1'b1;
                    end else if (req_we && req_size == SizeWord) begin
                        state_d     = StWr;
                        ram_we_d    = 1'b1;
                        ram_wdata_d = req_wdata;
                    end else begin
                        state_d = StRd;
                    end
                end
            end
            StRd: begin
                rd_d = ram_rdata;
                if (req_q.we) begin
                    state_d     = StWr;
                    ram_we_d    = 1'b1;
                    ram_wdata_d = merged;
                end else begin
                    state_d      = StResp;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = load_data;
                end
            end
            StWr: begin
                state_d      = StResp;
                resp_valid_d = 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= StIdle;
            req_q        <= '0;
            rd_q         <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_fault_q <= 1'b0;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            rd_q         <= rd_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_fault_q <= resp_fault_d;
            ram_we_q     <= ram_we_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
        end
    end

    assign req_ready  = (state_q == StIdle);
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_fault = resp_fault_q;
    // Gated by reset so a write pending in the reset cycle never reaches the RAM.
    assign ram_we     = ram_we_q & rstn;
    assign ram_addr   = ram_addr_q;
    assign ram_wdata  = ram_wdata_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with a 1 KiB async-read / 4-byte sync-write RAM model.
module tb_lsu_mem_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [9:0]  req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic        ram_we;
    logic [9:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    logic [7:0] mem [0:1023];
    int checks  = 0;
    int errors  = 0;
    int we_cnt  = 0;
    int overlap = 0;
    int cyc     = 0;

    always #5 clk = ~clk;

    lsu_mem_ctrl #(
        .ADDR_W (10),
        .DATA_W (32)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_fault   (resp_fault),
        .ram_we       (ram_we),
        .ram_addr     (ram_addr),
        .ram_wdata    (ram_wdata),
        .ram_rdata    (ram_rdata)
    );

    assign ram_rdata = {mem[ram_addr + 10'd3], mem[ram_addr + 10'd2],
                        mem[ram_addr + 10'd1], mem[ram_addr]};

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ram_we) begin
            mem[ram_addr]         <= ram_wdata[7:0];
            mem[ram_addr + 10'd1] <= ram_wdata[15:8];
            mem[ram_addr + 10'd2] <= ram_wdata[23:16];
            mem[ram_addr + 10'd3] <= ram_wdata[31:24];
            we_cnt <= we_cnt + 1;
        end
    end

    always @(negedge clk) begin
        if (resp_valid && req_ready) overlap <= overlap + 1;
    end

    function automatic logic [31:0] mem_word(input int a);
        return {mem[a+3], mem[a+2], mem[a+1], mem[a]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [9:0] addr, input logic [31:0] wdata);
        int n = 0;
        while (!req_ready && n < 8) begin
            tick();
            n++;
        end
        check("req_ready_before_accept", 32'(req_ready), 32'd1);
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        req_valid    = 1'b1;
        tick();
        req_valid    = 1'b0;
    endtask

    task automatic wait_resp(input string tag, input int exp_lat, input logic [31:0] exp_data,
                             input logic exp_fault);
        int lat = 1;
        while (!resp_valid && lat < 8) begin
            tick();
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_rdata"}, resp_rdata, exp_data);
        check({tag, "_fault"}, 32'(resp_fault), 32'(exp_fault));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "bench timed out");
    end

    initial begin
        int we0;
        int acc [5];
        int n;

        rstn         = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        tick();
        tick();
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_resp_fault", 32'(resp_fault), 32'd0);
        check("rst_ram_we", 32'(ram_we), 32'd0);
        check("rst_ram_addr", 32'(ram_addr), 32'd0);
        check("rst_ram_wdata", ram_wdata, 32'd0);
        rstn = 1'b1;
        tick();
        check("rst_req_ready", 32'(req_ready), 32'd1);

        // Word store then word load
        do_req(1'b1, 2'b10, 1'b0, 10'h010, 32'h8899_AABC);
        wait_resp("wst", 2, 32'd0, 1'b0);
        do_req(1'b0, 2'b10, 1'b0, 10'h010, 32'h0);
        wait_resp("wld", 2, 32'h8899_AABC, 1'b0);

        // Byte RMW and signed/unsigned byte loads
        do_req(1'b1, 2'b10, 1'b0, 10'h020, 32'h1122_3344);
        wait_resp("pre20", 2, 32'd0, 1'b0);
        we0 = we_cnt;
        do_req(1'b1, 2'b00, 1'b0, 10'h022, 32'h0000_00F0);
        wait_resp("bst", 3, 32'd0, 1'b0);
        check("bst_we_count", 32'(we_cnt - we0), 32'd1);
        check("bst_mem", mem_word(32'h020), 32'h11F0_3344);
        do_req(1'b0, 2'b00, 1'b0, 10'h022, 32'h0);
        wait_resp("bld_s", 2, 32'hFFFF_FFF0, 1'b0);
        do_req(1'b0, 2'b00, 1'b1, 10'h022, 32'h0);
        wait_resp("bld_u", 2, 32'h0000_00F0, 1'b0);

        // Top-of-RAM window clamp
        do_req(1'b1, 2'b10, 1'b0, 10'h3FC, 32'h1122_3344);
        wait_resp("pre3fc", 2, 32'd0, 1'b0);
        do_req(1'b0, 2'b00, 1'b1, 10'h3FF, 32'h0);
        check("top_ram_addr", 32'(ram_addr), 32'h3FC);
        wait_resp("top_bld", 2, 32'h0000_0011, 1'b0);
        do_req(1'b1, 2'b01, 1'b0, 10'h3FE, 32'h0000_BEEF);
        wait_resp("top_hst", 3, 32'd0, 1'b0);
        check("top_mem", mem_word(32'h3FC), 32'hBEEF_3344);
        do_req(1'b0, 2'b01, 1'b0, 10'h3FE, 32'h0);
        wait_resp("top_hld_s", 2, 32'hFFFF_BEEF, 1'b0);

        // Faults
        we0 = we_cnt;
        do_req(1'b1, 2'b10, 1'b0, 10'h3FD, 32'hDEAD_BEEF);
        wait_resp("flt_word", 1, 32'd0, 1'b1);
        do_req(1'b0, 2'b01, 1'b0, 10'h3FF, 32'h0);
        wait_resp("flt_half", 1, 32'd0, 1'b1);
        do_req(1'b1, 2'b11, 1'b0, 10'h000, 32'h1234_5678);
        wait_resp("flt_ill", 1, 32'd0, 1'b1);
        check("flt_we_count", 32'(we_cnt - we0), 32'd0);

        // Reset during the write cycle of a byte store
        do_req(1'b1, 2'b10, 1'b0, 10'h030, 32'hA5A5_A5A5);
        wait_resp("pre30", 2, 32'd0, 1'b0);
        we0 = we_cnt;
        do_req(1'b1, 2'b00, 1'b0, 10'h031, 32'h0000_003C);
        tick();
        check("rstwr_in_wr", 32'(dut.ram_we_q), 32'd1);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        check("rstwr_req_ready", 32'(req_ready), 32'd1);
        check("rstwr_resp_valid0", 32'(resp_valid), 32'd0);
        check("rstwr_ram_addr", 32'(ram_addr), 32'd0);
        tick();
        check("rstwr_resp_valid1", 32'(resp_valid), 32'd0);
        check("rstwr_we_count", 32'(we_cnt - we0), 32'd0);
        check("rstwr_mem", mem_word(32'h030), 32'hA5A5_A5A5);

        // Back-to-back with req_valid held high
        req_valid    = 1'b1;
        req_we       = 1'b0;
        req_size     = 2'b01;
        req_unsigned = 1'b0;
        req_addr     = 10'h3FF;
        req_wdata    = '0;
        for (int i = 0; i < 5; i++) begin
            n = 0;
            while (!req_ready && n < 10) begin
                tick();
                n++;
            end
            acc[i] = cyc;
            tick();
            case (i)
                0: begin req_we = 1'b0; req_size = 2'b10; req_addr = 10'h010; end
                1: begin req_we = 1'b1; req_size = 2'b10; req_addr = 10'h040;
                         req_wdata = 32'hCAFE_F00D; end
                2: begin req_we = 1'b1; req_size = 2'b00; req_addr = 10'h041;
                         req_wdata = 32'h0000_005A; end
                3: begin req_we = 1'b0; req_size = 2'b01; req_addr = 10'h041;
                         req_unsigned = 1'b1; end
                default: req_valid = 1'b0;
            endcase
        end
        wait_resp("b2b_hld_u", 2, 32'h0000_FE5A, 1'b0);
        check("b2b_gap_fault", 32'(acc[1] - acc[0]), 32'd2);
        check("b2b_gap_load", 32'(acc[2] - acc[1]), 32'd3);
        check("b2b_gap_wst", 32'(acc[3] - acc[2]), 32'd3);
        check("b2b_gap_bst", 32'(acc[4] - acc[3]), 32'd4);
        check("b2b_mem", mem_word(32'h040), 32'hCAFE_5A0D);
        tick();
        tick();
        check("no_resp_ready_overlap", 32'(overlap), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
